// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beat counter only has to reach max_burst-1.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: first set request at or above ptr_i, wrapping to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic                found_o
);

    int unsigned cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr_i) + i) % NUM_REQ;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = ID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter letting NUM_REQ bursting requesters share one FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  DATA_WIDTH = 8,
    parameter int unsigned  MAX_BURST  = 4,
    localparam int unsigned ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_last,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                fifo_full,
    output logic                                fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]      fifo_din,
    output logic                                grant_valid,
    output logic [ID_WIDTH-1:0]                 grant_id
);

    localparam int unsigned           CNT_WIDTH = cnt_width(MAX_BURST);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0]   ID_LAST   = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [ID_WIDTH-1:0]    pick_idx;
    logic                   pick_found;
    logic                   gnt_valid;
    logic                   end_grant;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign gnt_valid = req_valid[grant_id_q];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        end_grant  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d    = StGrant;
                    grant_id_d = pick_idx;
                    cnt_d      = '0;
                end
            end
            StGrant: begin
                req_ready[grant_id_q] = !fifo_full;
                fifo_wr_en            = gnt_valid && !fifo_full;
                // A full FIFO freezes everything, even a requester that drops valid.
                if (!fifo_full) begin
                    if (!gnt_valid || req_last[grant_id_q] || cnt_q == CNT_LAST) begin
                        end_grant = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                if (end_grant) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_id_q == ID_LAST) ? '0 : grant_id_q + ID_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (rst) begin
            req_ready  = '0;
            fifo_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant_valid = (state_q == StGrant) && !rst;
    assign grant_id    = grant_id_q;
    assign fifo_din    = {grant_id_q, req_data[grant_id_q]};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; FIFO writes are matched against a queue of expected words.
module tb_fifo_wr_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_last;
    logic [3:0][7:0]  req_data;
    logic [3:0]       req_ready;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [9:0]       fifo_din;
    logic             grant_valid;
    logic [1:0]       grant_id;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        logic [1:0] idb;
        idb = 2'(id);
        exp_q.push_back({idb, d});
    endtask

    task automatic chk_state(input string tag, input logic gv, input int gid, input logic [3:0] rdy,
                             input logic wr);
        chk({tag, " grant_valid"}, 32'(grant_valid), 32'(gv));
        if (gv) chk({tag, " grant_id"}, 32'(grant_id), gid);
        chk({tag, " req_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, " fifo_wr_en"}, 32'(fifo_wr_en), 32'(wr));
    endtask

    // Scoreboard: every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            chk("write while full", 32'(fifo_full), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected write", 32'(fifo_din), 32'h3ff_ffff);
            end else begin
                chk("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'hf;
        req_last  = 4'h0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Reset holds outputs low even with every requester valid.
        tick();
        tick();
        #1;
        chk_state("reset", 1'b0, 0, 4'h0, 1'b0);
        req_valid = 4'h0;
        tick();
        rst = 1'b0;
        #1;
        chk_state("post reset", 1'b0, 0, 4'h0, 1'b0);
        chk("post reset grant_id", 32'(grant_id), 0);

        // Single requester 2, three beats with last on the third.
        push(2, 8'ha1);
        push(2, 8'ha2);
        push(2, 8'ha3);
        tick();
        req_valid = 4'b0100;
        req_data[2] = 8'ha1;
        #1;
        chk_state("single bubble", 1'b0, 0, 4'h0, 1'b0);
        tick();
        #1;
        chk_state("single beat1", 1'b1, 2, 4'b0100, 1'b1);
        tick();
        req_data[2] = 8'ha2;
        #1;
        chk_state("single beat2", 1'b1, 2, 4'b0100, 1'b1);
        tick();
        req_data[2] = 8'ha3;
        req_last[2] = 1'b1;
        #1;
        chk_state("single beat3", 1'b1, 2, 4'b0100, 1'b1);
        tick();
        req_valid = 4'h0;
        req_last  = 4'h0;
        #1;
        chk_state("single end", 1'b0, 0, 4'h0, 1'b0);

        // Wrap: pointer at 3 with requesters 1 and 3 valid picks 3 first.
        push(3, 8'h33);
        push(1, 8'h11);
        tick();
        req_valid   = 4'b1010;
        req_last    = 4'b1010;
        req_data[1] = 8'h11;
        req_data[3] = 8'h33;
        tick();
        #1;
        chk_state("wrap first", 1'b1, 3, 4'b1000, 1'b1);
        tick();
        req_valid = 4'b0010;
        #1;
        chk_state("wrap bubble", 1'b0, 0, 4'h0, 1'b0);
        tick();
        #1;
        chk_state("wrap second", 1'b1, 1, 4'b0010, 1'b1);
        tick();
        req_valid = 4'h0;
        req_last  = 4'h0;

        // All four valid with no last: full-length bursts in strict rotation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i] = 8'hc0 | 8'(i);
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) push(g % 4, 8'hc0 | 8'(g % 4));
        end
        req_valid = 4'hf;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk_state($sformatf("rr bubble %0d", g), 1'b0, 0, 4'h0, 1'b0);
            tick();
            for (int b = 0; b < 4; b++) begin
                #1;
                chk_state($sformatf("rr grant %0d beat %0d", g, b), 1'b1, g % 4,
                          4'(1 << (g % 4)), 1'b1);
                tick();
            end
        end
        req_valid = 4'h0;

        // FIFO full for five cycles mid-burst; a valid drop while full must not end the grant.
        push(1, 8'hb0);
        push(1, 8'hb1);
        push(1, 8'hb2);
        push(1, 8'hb3);
        tick();
        req_valid   = 4'b0010;
        req_data[1] = 8'hb0;
        tick();
        #1;
        chk_state("full beat0", 1'b1, 1, 4'b0010, 1'b1);
        tick();
        req_data[1] = 8'hb1;
        fifo_full   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 2) ? 4'b0000 : 4'b0010;
            #1;
            chk_state($sformatf("full hold %0d", c), 1'b1, 1, 4'h0, 1'b0);
            tick();
        end
        fifo_full = 1'b0;
        req_valid = 4'b0010;
        for (int b = 1; b < 4; b++) begin
            req_data[1] = 8'hb0 + 8'(b);
            #1;
            chk_state($sformatf("full resume %0d", b), 1'b1, 1, 4'b0010, 1'b1);
            tick();
        end
        req_valid = 4'h0;
        #1;
        chk_state("full burst end", 1'b0, 0, 4'h0, 1'b0);

        // Abandoned burst: requester 2 drops valid after one beat, requester 0 waits.
        push(2, 8'hd0);
        push(0, 8'he0);
        tick();
        req_valid   = 4'b0101;
        req_last    = 4'b0001;
        req_data[2] = 8'hd0;
        req_data[0] = 8'he0;
        tick();
        #1;
        chk_state("abandon beat", 1'b1, 2, 4'b0100, 1'b1);
        tick();
        req_valid = 4'b0001;
        #1;
        chk_state("abandon drop", 1'b1, 2, 4'b0100, 1'b0);
        tick();
        #1;
        chk_state("abandon bubble", 1'b0, 0, 4'h0, 1'b0);
        tick();
        #1;
        chk_state("abandon next", 1'b1, 0, 4'b0001, 1'b1);
        tick();
        req_valid = 4'h0;
        req_last  = 4'h0;

        // Reset during beat 2: no write that cycle, pointer back to 0 so requester 0 wins.
        push(2, 8'hf0);
        push(0, 8'h5a);
        tick();
        req_valid   = 4'b0100;
        req_data[2] = 8'hf0;
        tick();
        #1;
        chk_state("rst beat1", 1'b1, 2, 4'b0100, 1'b1);
        tick();
        rst         = 1'b1;
        req_data[2] = 8'hf1;
        req_valid   = 4'b0101;
        req_last    = 4'b0001;
        req_data[0] = 8'h5a;
        #1;
        chk_state("rst cycle", 1'b0, 0, 4'h0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk_state("rst after", 1'b0, 0, 4'h0, 1'b0);
        chk("rst after grant_id", 32'(grant_id), 0);
        tick();
        #1;
        chk_state("rst pointer", 1'b1, 0, 4'b0001, 1'b1);
        tick();
        req_valid = 4'h0;
        req_last  = 4'h0;
        tick();
        tick();

        chk("pending writes", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one FIFO write port (legal range 2..16).
REQ-002 Parameter DATA_WIDTH, default 8, payload width per requester.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant (legal range 1..256).
REQ-004 Derived constant ID_WIDTH SHALL be $clog2(NUM_REQ).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  NUM_REQ  per-requester data valid.
REQ-008 req_last  input  NUM_REQ  per-requester end-of-burst marker, qualified by req_valid.
REQ-009 req_data  input  NUM_REQ x DATA_WIDTH  per-requester payload.
REQ-010 req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both 1.
REQ-011 fifo_full  input  1  full flag from the downstream FIFO.
REQ-012 fifo_wr_en  output  1  FIFO write enable.
REQ-013 fifo_din  output  ID_WIDTH+DATA_WIDTH  {grant_id, payload} written to the FIFO.
REQ-014 grant_valid  output  1  a requester currently holds the grant.
REQ-015 grant_id  output  ID_WIDTH  index of the granted requester.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-017 In IDLE, if any req_valid is 1, the FSM SHALL move to GRANT next cycle with grant_id = first requester with req_valid=1 searching upward from rr_ptr, wrapping NUM_REQ-1 to 0.
REQ-018 In IDLE, req_ready SHALL be all-zero (one-cycle arbitration bubble before the first beat).
REQ-019 In GRANT, req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-020 fifo_wr_en SHALL equal req_valid[grant_id] & req_ready[grant_id] combinationally; it SHALL never be 1 while fifo_full=1.
REQ-021 fifo_din SHALL equal {grant_id, req_data[grant_id]}; its value is don't-care when fifo_wr_en=0.
REQ-022 A beat counter SHALL clear on entry to GRANT and increment on each transferred beat.
REQ-023 In GRANT, a beat with req_last=1, or a beat where the counter equals MAX_BURST-1, SHALL end the grant: FSM to IDLE, rr_ptr <= grant_id+1 modulo NUM_REQ.
REQ-024 In GRANT, req_valid[grant_id]=0 for one cycle with fifo_full=0 SHALL end the grant the same way (abandoned burst).
REQ-025 While fifo_full=1 in GRANT, grant, counter and FSM SHALL hold; req_valid dropping during full SHALL NOT end the grant.
REQ-026 grant_valid SHALL be 1 exactly when the FSM is in GRANT.
REQ-027 A requester that raises req_valid while another holds the grant SHALL wait; no requester SHALL be skipped twice in a row while continuously valid (round-robin fairness).

Reset
REQ-028 On rst=1 at a clock edge: FSM=IDLE, rr_ptr=0, beat counter=0, grant_id=0.
REQ-029 While rst=1, req_ready, fifo_wr_en and grant_valid SHALL be 0 regardless of other inputs.
REQ-030 Reset asserted mid-burst SHALL abandon the burst; no beat transfers in the reset cycle.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the FSM state enum and the ID_WIDTH/counter-width helper functions.
REQ-032 Sub-module rr_pick (combinational: req vector + pointer -> winner index, found flag) SHALL implement the wrap-around priority search.
REQ-033 rr_ptr, grant_id, beat counter and FSM state SHALL be the only registers; datapath is pass-through.

Verification
REQ-034 Single requester: req 2 sends 3 beats 0xA1,0xA2,0xA3 with last on 3rd -> one idle bubble, then 3 consecutive writes {2,0xA1..0xA3}, rr_ptr=3.
REQ-035 All four valid continuously, no last, MAX_BURST=4 -> grants 0,1,2,3,0 each of exactly 4 beats, one bubble between grants.
REQ-036 fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 those cycles, grant and count unchanged, burst resumes after.
REQ-037 Granted requester drops valid after 1 beat -> grant ends, next valid requester granted after one bubble.
REQ-038 rst=1 during beat 2 of a burst -> next cycle grant_valid=0, rr_ptr=0, no FIFO write in reset cycle.
REQ-039 Wrap: rr_ptr=3, requesters 1 and 3 valid -> requester 3 granted first, then requester 1.
